// File: rtl/sram_1rw_init_ext.sv
// 1RW SRAM model with per-group write mask and a hardware init sweep after reset or on init_req.
// Read latency 1 cycle; RW0_ready is a decode of the FSM state only.
// Requests presented while RW0_ready is low are dropped, never queued.
module sram_1rw_init_ext #(
    parameter int                    DATA_WIDTH    = 76,
    parameter int                    DEPTH         = 128,
    parameter int                    ADDR_WIDTH    = $clog2(DEPTH),
    parameter int                    MASK_WIDTH    = 76,
    parameter bit                    INIT_ON_RESET = 1'b1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE    = '0,
    parameter bit                    HOLD_RDATA    = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] RW0_addr,
    input  logic                  RW0_en,
    input  logic                  RW0_wmode,
    input  logic [MASK_WIDTH-1:0] RW0_wmask,
    input  logic [DATA_WIDTH-1:0] RW0_wdata,
    output logic [DATA_WIDTH-1:0] RW0_rdata,
    output logic                  RW0_ready,
    input  logic                  init_req,
    output logic                  init_busy
);
    localparam int                    GROUP_WIDTH = DATA_WIDTH / MASK_WIDTH;
    localparam logic [ADDR_WIDTH:0]   DEPTH_W     = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [DATA_WIDTH-1:0] OOB_VALUE   = INIT_ON_RESET ? INIT_VALUE : '0;

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] cnt;
    logic [DATA_WIDTH-1:0] ram [DEPTH];
    logic [DATA_WIDTH-1:0] bitmask;
    logic                  addr_ok;
    logic                  wr_fire;
    logic                  rd_fire;

    always_comb begin
        bitmask = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            bitmask[i] = RW0_wmask[i / GROUP_WIDTH];
        end
    end

    assign RW0_ready = (state == ST_READY);
    assign init_busy = (state == ST_INIT);
    assign addr_ok   = ({1'b0, RW0_addr} < DEPTH_W);
    assign wr_fire   = RW0_ready & RW0_en & RW0_wmode & addr_ok;
    assign rd_fire   = RW0_ready & RW0_en & ~RW0_wmode;

    // init_req in READY still lets the request on that edge complete; the sweep follows.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= INIT_ON_RESET ? ST_INIT : ST_READY;
            cnt   <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    if (cnt == LAST_ADDR) begin
                        state <= ST_READY;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    if (init_req) begin
                        state <= ST_INIT;
                        cnt   <= '0;
                    end
                end
            endcase
        end
    end

    // Gated by reset_n so the array is left untouched while reset is held.
    always_ff @(posedge clock) begin
        if (reset_n && state == ST_INIT) begin
            ram[cnt] <= INIT_VALUE;
        end else if (wr_fire) begin
            ram[RW0_addr] <= (RW0_wdata & bitmask) | (ram[RW0_addr] & ~bitmask);
        end
    end

    if (HOLD_RDATA) begin : g_hold
        logic [DATA_WIDTH-1:0] rdata_q;

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                rdata_q <= '0;
            end else if (rd_fire) begin
                rdata_q <= addr_ok ? ram[RW0_addr] : OOB_VALUE;
            end
        end

        assign RW0_rdata = rdata_q;
    end else begin : g_flow
        logic [ADDR_WIDTH-1:0] rd_addr_q;

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                rd_addr_q <= '0;
            end else if (rd_fire) begin
                rd_addr_q <= RW0_addr;
            end
        end

        // Follows later writes to the captured address, including the sweep.
        assign RW0_rdata = ({1'b0, rd_addr_q} < DEPTH_W) ? ram[rd_addr_q] : OOB_VALUE;
    end

endmodule

// File: tb/tb_sram_1rw_init_ext.sv
// Bench for sram_1rw_init_ext: a 128-deep holding instance and a 100-deep flow-through instance.
module tb_sram_1rw_init_ext;
    localparam logic [75:0] IV = 76'h5A;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [6:0]  addr;
    logic        en, wmode, init_req;
    logic [3:0]  wmask;
    logic [75:0] wdata, rdata;
    logic        ready, busy;

    logic [6:0]  addr2;
    logic        en2, wmode2, init_req2;
    logic [75:0] wmask2, wdata2, rdata2;
    logic        ready2, busy2;

    int n_checks = 0;
    int n_errors = 0;

    logic [75:0] sb_q[$];
    string       tag_q[$];
    logic        rd_issue = 1'b0;
    logic        rd_fire_q = 1'b0;

    always #5 clk = ~clk;

    sram_1rw_init_ext #(
        .DATA_WIDTH(76), .DEPTH(128), .MASK_WIDTH(4),
        .INIT_ON_RESET(1'b1), .INIT_VALUE(IV), .HOLD_RDATA(1'b1)
    ) dut (
        .clock(clk), .reset_n(reset_n), .RW0_addr(addr), .RW0_en(en),
        .RW0_wmode(wmode), .RW0_wmask(wmask), .RW0_wdata(wdata),
        .RW0_rdata(rdata), .RW0_ready(ready), .init_req(init_req), .init_busy(busy)
    );

    sram_1rw_init_ext #(
        .DATA_WIDTH(76), .DEPTH(100), .MASK_WIDTH(76),
        .INIT_ON_RESET(1'b1), .INIT_VALUE(IV), .HOLD_RDATA(1'b0)
    ) dut2 (
        .clock(clk), .reset_n(reset_n), .RW0_addr(addr2), .RW0_en(en2),
        .RW0_wmode(wmode2), .RW0_wmask(wmask2), .RW0_wdata(wdata2),
        .RW0_rdata(rdata2), .RW0_ready(ready2), .init_req(init_req2), .init_busy(busy2)
    );

    task automatic chk(input string tag, input logic [75:0] got, input logic [75:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard: reads accepted on a posedge are compared on the following negedge.
    always @(posedge clk) rd_fire_q <= rd_issue;

    always @(negedge clk) begin
        if (rd_fire_q) begin
            chk("sb_nonempty", 76'(sb_q.size() > 0), 76'(1));
            if (sb_q.size() > 0) chk(tag_q.pop_front(), rdata, sb_q.pop_front());
        end
    end

    task automatic rd(input logic [6:0] a, input logic [75:0] e, input string tag);
        en = 1'b1; wmode = 1'b0; addr = a; rd_issue = 1'b1;
        sb_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk);
        en = 1'b0; rd_issue = 1'b0;
    endtask

    task automatic wr(input logic [6:0] a, input logic [75:0] d, input logic [3:0] m);
        en = 1'b1; wmode = 1'b1; addr = a; wdata = d; wmask = m;
        @(negedge clk);
        en = 1'b0; wmode = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wr2(input logic [6:0] a, input logic [75:0] d);
        en2 = 1'b1; wmode2 = 1'b1; addr2 = a; wdata2 = d; wmask2 = '1;
        @(negedge clk);
        en2 = 1'b0; wmode2 = 1'b0;
    endtask

    task automatic rd2(input logic [6:0] a, input logic [75:0] e, input string tag);
        en2 = 1'b1; wmode2 = 1'b0; addr2 = a;
        @(negedge clk);
        en2 = 1'b0;
        chk(tag, rdata2, e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int          n, n2;
        logic [75:0] exp_mask;

        reset_n = 1'b0;
        en = 1'b0; wmode = 1'b0; addr = '0; wmask = '0; wdata = '0; init_req = 1'b0;
        en2 = 1'b0; wmode2 = 1'b0; addr2 = '0; wmask2 = '0; wdata2 = '0; init_req2 = 1'b0;
        idle(3);
        chk("rst_rdata", rdata, '0);
        chk("rst_ready", 76'(ready), 76'(0));
        chk("rst_busy", 76'(busy), 76'(1));
        chk("rst_ready2", 76'(ready2), 76'(0));

        // Reset sweep with a dropped write and an ignored init_req along the way.
        reset_n = 1'b1;
        n = 0; n2 = -1;
        while (!ready && n < 1000) begin
            if (ready2 && n2 == -1) n2 = n;
            en = 1'b0; wmode = 1'b0; init_req = 1'b0;
            if (n == 20) begin en = 1'b1; wmode = 1'b1; addr = 7'd10; wdata = '1; wmask = '1; end
            if (n == 30) init_req = 1'b1;
            @(negedge clk);
            n++;
        end
        en = 1'b0; wmode = 1'b0; init_req = 1'b0;
        chk("sweep_len", 76'(n), 76'(128));
        chk("sweep_len2", 76'(n2), 76'(100));
        chk("busy_after_sweep", 76'(busy), 76'(0));
        rd(7'd0, IV, "init_a0");
        rd(7'd64, IV, "init_a64");
        rd(7'd127, IV, "init_a127");
        rd(7'd10, IV, "dropped_wr_a10");

        // Masked write: groups 1 and 3 keep their ones.
        wr(7'd3, '1, 4'b1111);
        wr(7'd3, '0, 4'b0101);
        exp_mask = '0;
        exp_mask[75:57] = '1;
        exp_mask[37:19] = '1;
        rd(7'd3, exp_mask, "masked_wr");
        wr(7'd20, 76'hABCDE, 4'b1111);
        rd(7'd20, 76'hABCDE, "raw_back_to_back");

        // Held read data through a write and an idle cycle.
        wr(7'd7, 76'h11, 4'b1111);
        rd(7'd7, 76'h11, "hold_rd1");
        wr(7'd7, 76'h22, 4'b1111);
        chk("hold_thru_wr", rdata, 76'h11);
        idle(1);
        chk("hold_thru_idle", rdata, 76'h11);
        rd(7'd7, 76'h22, "hold_rd2");

        // Re-init; the read on the init_req edge still returns the old word.
        wr(7'd5, 76'h33, 4'b1111);
        init_req = 1'b1;
        rd(7'd5, 76'h33, "rd_on_init_edge");
        init_req = 1'b0;
        chk("reinit_ready_low", 76'(ready), 76'(0));
        wait_ready(n);
        chk("reinit_len", 76'(n), 76'(128));
        rd(7'd5, IV, "reinit_a5");

        // Reset during a sweep restarts it from address 0.
        wr(7'd60, 76'h99, 4'b1111);
        wr(7'd127, 76'h99, 4'b1111);
        rd(7'd127, 76'h99, "pre_reset_rd");
        init_req = 1'b1;
        idle(1);
        init_req = 1'b0;
        idle(50);
        reset_n = 1'b0;
        idle(2);
        chk("midrst_rdata", rdata, '0);
        chk("midrst_busy", 76'(busy), 76'(1));
        reset_n = 1'b1;
        wait_ready(n);
        chk("midrst_len", 76'(n), 76'(128));
        for (int a = 0; a < 128; a++) rd(7'(a), IV, $sformatf("midrst_a%0d", a));

        // Non-power-of-two depth, flow-through read data.
        chk("ready2_after", 76'(ready2), 76'(1));
        wr2(7'd110, '1);
        rd2(7'd110, IV, "oob_rd110");
        rd2(7'd10, IV, "oob_no_alias10");
        rd2(7'd46, IV, "oob_no_alias46");
        wr2(7'd50, 76'h44);
        rd2(7'd50, 76'h44, "flow_rd50");
        wr2(7'd50, 76'h55);
        chk("flow_tracks_wr", rdata2, 76'h55);

        idle(2);
        chk("sb_drained", 76'(sb_q.size()), 76'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
